// File: rtl/ft_dds_pkg.sv
// ---------------------------------------------------------------------------
// ft_dds_pkg: shared constants, state encodings and helpers for the FT245 DDS controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ft_dds_pkg;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h5A;
  localparam logic [7:0] NAK = 8'hEE;

  localparam logic [7:0] CMD_TW   = 8'h01;
  localparam logic [7:0] CMD_WAVE = 8'h02;
  localparam logic [7:0] CMD_EN   = 8'h03;

  localparam logic [2:0] WAVE_SIN = 3'b001;
  localparam logic [2:0] WAVE_TRI = 3'b010;
  localparam logic [2:0] WAVE_SQU = 3'b100;

  typedef enum logic [2:0] {
    BIF_IDLE      = 3'd0,
    BIF_RD_STROBE = 3'd1,
    BIF_RD_RECOV  = 3'd2,
    BIF_TX_STROBE = 3'd3,
    BIF_TX_HOLD   = 3'd4
  } bif_state_e;

  typedef enum logic [2:0] {
    PS_HUNT = 3'd0,
    PS_CMD  = 3'd1,
    PS_P1   = 3'd2,
    PS_P0   = 3'd3,
    PS_CHK  = 3'd4
  } parse_state_e;

  // Code 3 has no waveform; callers reject it before using the result.
  function automatic logic [2:0] wave_decode(input logic [1:0] code);
    logic [2:0] sel;
    sel = 3'b000;
    case (code)
      2'd0:    sel = WAVE_SIN;
      2'd1:    sel = WAVE_TRI;
      2'd2:    sel = WAVE_SQU;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ft245_byte_if.sv
// ---------------------------------------------------------------------------
// ft245_byte_if: FT245 read/write strobe sequencer with byte capture and tx handshake. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ft245_byte_if
  import ft_dds_pkg::*;
#(
  parameter int unsigned RD_WAIT  = 4,
  parameter int unsigned RD_RECOV = 2,
  parameter int unsigned WR_PULSE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxf_n_i,
  input  logic       txe_n_i,
  input  logic [7:0] d_in_i,
  input  logic       rx_hold_i,
  input  logic       tx_req_i,
  input  logic [7:0] tx_data_i,
  output logic       rd_n_o,
  output logic       wr_o,
  output logic       d_oe_o,
  output logic [7:0] d_out_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       tx_done_o
);

  localparam int unsigned CNT_MAX =
    (RD_WAIT > RD_RECOV) ? ((RD_WAIT  > WR_PULSE) ? RD_WAIT  : WR_PULSE)
                         : ((RD_RECOV > WR_PULSE) ? RD_RECOV : WR_PULSE);
  localparam int unsigned CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RD_LAST    = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] RECOV_LAST = CW'(RD_RECOV - 1);
  localparam logic [CW-1:0] WR_LAST    = CW'(WR_PULSE - 1);

  bif_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    d_out_q, d_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BIF_IDLE;
      cnt_q      <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      d_out_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      d_out_q    <= d_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    d_out_d    = d_out_q;
    case (state_q)
      BIF_IDLE: begin
        cnt_d = '0;
        // Transmit wins; a pending or about-to-be-pending response blocks reads.
        if (tx_req_i && !txe_n_i) begin
          state_d = BIF_TX_STROBE;
          d_out_d = tx_data_i;
        end else if (!tx_req_i && !rx_hold_i && !rxf_n_i) begin
          state_d = BIF_RD_STROBE;
        end
      end
      BIF_RD_STROBE: begin
        if (cnt_q == RD_LAST) begin
          rx_data_d  = d_in_i;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = BIF_RD_RECOV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BIF_RD_RECOV: begin
        if (cnt_q == RECOV_LAST) begin
          cnt_d   = '0;
          state_d = BIF_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BIF_TX_STROBE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = BIF_TX_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BIF_TX_HOLD: state_d = BIF_IDLE;
      default:     state_d = BIF_IDLE;
    endcase
  end

  assign rd_n_o     = (state_q != BIF_RD_STROBE);
  assign wr_o       = (state_q == BIF_TX_STROBE);
  assign d_oe_o     = (state_q == BIF_TX_STROBE) || (state_q == BIF_TX_HOLD);
  assign d_out_o    = d_out_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign tx_done_o  = (state_q == BIF_TX_HOLD);

endmodule

`default_nettype wire

// File: rtl/ft245_dds_ctrl.sv
// ---------------------------------------------------------------------------
// ft245_dds_ctrl: parses 5-byte host frames and drives the DDS tuning/waveform registers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ft245_dds_ctrl
  import ft_dds_pkg::*;
#(
  parameter int unsigned RD_WAIT  = 4,
  parameter int unsigned RD_RECOV = 2,
  parameter int unsigned WR_PULSE = 3,
  parameter int unsigned TIMEOUT  = 1_000_000,
  parameter logic [15:0] TW_RESET = 16'd2621
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxf_n,
  input  logic        txe_n,
  output logic        rd_n,
  output logic        wr,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic        key_step,
  output logic [15:0] tuning_word,
  output logic [2:0]  wave_sel,
  output logic        da_en,
  output logic        cfg_update,
  output logic [7:0]  frame_err_cnt
);

  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_done;

  parse_state_e   parse_q, parse_d;
  logic [7:0]     cmd_q, cmd_d, p1_q, p1_d, p0_q, p0_d, chk_q, chk_d;
  logic           exec_q, exec_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout;

  logic        pending_q, pending_d;
  logic [7:0]  resp_q, resp_d;
  logic [15:0] tw_q, tw_d;
  logic [2:0]  wave_q, wave_d;
  logic        en_q, en_d;
  logic        cfg_q, cfg_d;
  logic [7:0]  err_q, err_d;
  logic        nak;
  logic        chk_ok;
  logic        wave_cmd_exec;

  ft245_byte_if #(
    .RD_WAIT  (RD_WAIT),
    .RD_RECOV (RD_RECOV),
    .WR_PULSE (WR_PULSE)
  ) u_byte_if (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxf_n_i    (rxf_n),
    .txe_n_i    (txe_n),
    .d_in_i     (d_in),
    .rx_hold_i  (exec_q),
    .tx_req_i   (pending_q),
    .tx_data_i  (resp_q),
    .rd_n_o     (rd_n),
    .wr_o       (wr),
    .d_oe_o     (d_oe),
    .d_out_o    (d_out),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .tx_done_o  (tx_done)
  );

  always_comb begin
    parse_d  = parse_q;
    cmd_d    = cmd_q;
    p1_d     = p1_q;
    p0_d     = p0_q;
    chk_d    = chk_q;
    exec_d   = 1'b0;
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (rx_valid) begin
      to_cnt_d = '0;
      case (parse_q)
        PS_HUNT: if (rx_data == HDR) parse_d = PS_CMD;
        PS_CMD:  begin cmd_d = rx_data; parse_d = PS_P1; end
        PS_P1:   begin p1_d  = rx_data; parse_d = PS_P0; end
        PS_P0:   begin p0_d  = rx_data; parse_d = PS_CHK; end
        PS_CHK:  begin chk_d = rx_data; exec_d = 1'b1; parse_d = PS_HUNT; end
        default: parse_d = PS_HUNT;
      endcase
    end else if (parse_q != PS_HUNT) begin
      if (to_cnt_q == TO_LAST) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
        parse_d  = PS_HUNT;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  assign chk_ok        = ((cmd_q ^ p1_q ^ p0_q) == chk_q);
  assign wave_cmd_exec = exec_q && chk_ok && (cmd_q == CMD_WAVE);

  always_comb begin
    tw_d      = tw_q;
    wave_d    = wave_q;
    en_d      = en_q;
    resp_d    = resp_q;
    pending_d = pending_q && !tx_done;
    nak       = 1'b0;
    if (key_step && en_q && !wave_cmd_exec) begin
      wave_d = {wave_q[1:0], wave_q[2]};
    end
    if (exec_q) begin
      pending_d = 1'b1;
      if (!chk_ok) begin
        nak = 1'b1;
      end else begin
        case (cmd_q)
          CMD_TW:   tw_d = {p1_q, p0_q};
          CMD_WAVE: begin
            if (p0_q[1:0] == 2'd3) nak = 1'b1;
            else                   wave_d = wave_decode(p0_q[1:0]);
          end
          CMD_EN:   en_d = p0_q[0];
          default:  nak = 1'b1;
        endcase
      end
      resp_d = nak ? NAK : ACK;
    end
  end

  always_comb begin
    err_d = err_q;
    if ((nak || timeout) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    cfg_d = (tw_d != tw_q) || (wave_d != wave_q) || (en_d != en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parse_q   <= PS_HUNT;
      cmd_q     <= 8'h00;
      p1_q      <= 8'h00;
      p0_q      <= 8'h00;
      chk_q     <= 8'h00;
      exec_q    <= 1'b0;
      to_cnt_q  <= '0;
      pending_q <= 1'b0;
      resp_q    <= 8'h00;
      tw_q      <= TW_RESET;
      wave_q    <= WAVE_SIN;
      en_q      <= 1'b1;
      cfg_q     <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      parse_q   <= parse_d;
      cmd_q     <= cmd_d;
      p1_q      <= p1_d;
      p0_q      <= p0_d;
      chk_q     <= chk_d;
      exec_q    <= exec_d;
      to_cnt_q  <= to_cnt_d;
      pending_q <= pending_d;
      resp_q    <= resp_d;
      tw_q      <= tw_d;
      wave_q    <= wave_d;
      en_q      <= en_d;
      cfg_q     <= cfg_d;
      err_q     <= err_d;
    end
  end

  assign tuning_word   = tw_q;
  assign wave_sel      = wave_q;
  assign da_en         = en_q;
  assign cfg_update    = cfg_q;
  assign frame_err_cnt = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ft245_dds_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ft245_dds_ctrl: directed self-checking bench with an FT245 FIFO model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ft245_dds_ctrl;

  localparam int unsigned TB_TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxf_n;
  logic        txe_n = 1'b0;
  logic        rd_n;
  logic        wr;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        key_step = 1'b0;
  logic [15:0] tuning_word;
  logic [2:0]  wave_sel;
  logic        da_en;
  logic        cfg_update;
  logic [7:0]  frame_err_cnt;

  int checks = 0;
  int failures = 0;

  // Host-to-device bytes (written by stimulus) and device-to-host log (written by monitor)
  logic [7:0] rx_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] tx_mem [256];
  int         tx_cnt = 0;

  int   rd_run = 0, rd_strobes = 0, rd_bad = 0, overlap = 0;
  int   wr_run = 0, wr_pulses = 0, wr_bad = 0, hold_run = 0, hold_bad = 0;
  int   cfg_pulses = 0;
  logic prev_rd = 1'b1, prev_wr = 1'b0;

  assign rxf_n = (rd_ptr == wr_ptr);
  assign d_in  = rx_mem[rd_ptr];

  always #5 clk = ~clk;

  ft245_dds_ctrl #(
    .RD_WAIT  (4),
    .RD_RECOV (2),
    .WR_PULSE (3),
    .TIMEOUT  (TB_TIMEOUT),
    .TW_RESET (16'd2621)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxf_n         (rxf_n),
    .txe_n         (txe_n),
    .rd_n          (rd_n),
    .wr            (wr),
    .d_in          (d_in),
    .d_out         (d_out),
    .d_oe          (d_oe),
    .key_step      (key_step),
    .tuning_word   (tuning_word),
    .wave_sel      (wave_sel),
    .da_en         (da_en),
    .cfg_update    (cfg_update),
    .frame_err_cnt (frame_err_cnt)
  );

  always @(negedge clk) begin
    prev_rd <= rd_n;
    prev_wr <= wr;
    if (!prev_rd && rd_n) begin
      rd_ptr     <= rd_ptr + 1;
      rd_strobes <= rd_strobes + 1;
      if (rd_run != 4) rd_bad <= rd_bad + 1;
      rd_run <= 0;
    end else if (!rd_n) begin
      rd_run <= rd_run + 1;
    end
    if (!rd_n && d_oe) overlap <= overlap + 1;
    if (prev_wr && !wr) begin
      wr_pulses <= wr_pulses + 1;
      if (wr_run != 3) wr_bad <= wr_bad + 1;
      wr_run <= 0;
      if (d_oe) begin
        tx_mem[tx_cnt[7:0]] <= d_out;
        tx_cnt <= tx_cnt + 1;
      end
    end else if (wr) begin
      wr_run <= wr_run + 1;
    end
    if (d_oe && !wr) begin
      hold_run <= hold_run + 1;
    end else if (!d_oe && hold_run != 0) begin
      if (hold_run != 1) hold_bad <= hold_bad + 1;
      hold_run <= 0;
    end
    if (cfg_update) cfg_pulses <= cfg_pulses + 1;
  end

  task automatic push_byte(input logic [7:0] b);
    rx_mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3); push_byte(b4);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 3000 && tx_cnt < target; i++) @(negedge clk);
    wait_cycles(4);
  endtask

  task automatic key_pulse();
    @(negedge clk); key_step = 1'b1;
    @(negedge clk); key_step = 1'b0;
    wait_cycles(3);
  endtask

  task automatic test_reset();
    wait_cycles(2);
    #1;
    checks++; if (rd_n !== 1'b1) begin failures++; $display("FAIL reset_rd_n: got %b expected 1", rd_n); end
    checks++; if (wr !== 1'b0 || d_oe !== 1'b0) begin failures++; $display("FAIL reset_wr_oe: got wr=%b d_oe=%b expected 0/0", wr, d_oe); end
    checks++; if (d_out !== 8'h00) begin failures++; $display("FAIL reset_d_out: got %h expected 00", d_out); end
    checks++; if (tuning_word !== 16'h0A3D) begin failures++; $display("FAIL reset_tw: got %h expected 0a3d", tuning_word); end
    checks++; if (wave_sel !== 3'b001 || da_en !== 1'b1) begin failures++; $display("FAIL reset_wave_en: got %b/%b expected 001/1", wave_sel, da_en); end
    checks++; if (cfg_update !== 1'b0 || frame_err_cnt !== 8'd0) begin failures++; $display("FAIL reset_cfg_err: got %b/%0d expected 0/0", cfg_update, frame_err_cnt); end
    @(negedge clk); rst_n = 1'b1;
    wait_cycles(5);
    checks++; if (rd_n !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL idle_quiet: got rd_n=%b wr=%b expected 1/0", rd_n, wr); end
  endtask

  task automatic test_tuning_word();
    int t0, p0, s0, rb, wb, hb, ov;
    t0 = tx_cnt; p0 = cfg_pulses; s0 = rd_strobes; rb = rd_bad; wb = wr_bad; hb = hold_bad; ov = overlap;
    send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    wait_tx(t0 + 1);
    checks++; if (tx_cnt !== t0 + 1) begin failures++; $display("FAIL tw_resp_count: got %0d expected %0d", tx_cnt - t0, 1); end
    checks++; if (tx_mem[t0[7:0]] !== 8'h5A) begin failures++; $display("FAIL tw_ack: got %h expected 5a", tx_mem[t0[7:0]]); end
    checks++; if (tuning_word !== 16'h1234) begin failures++; $display("FAIL tw_value: got %h expected 1234", tuning_word); end
    checks++; if (cfg_pulses - p0 !== 1) begin failures++; $display("FAIL tw_cfg_pulse: got %0d expected 1", cfg_pulses - p0); end
    checks++; if (rd_strobes - s0 !== 5 || rd_bad !== rb) begin failures++; $display("FAIL rd_strobe_shape: got strobes=%0d bad=%0d expected 5/0", rd_strobes - s0, rd_bad - rb); end
    checks++; if (overlap !== ov) begin failures++; $display("FAIL rd_oe_overlap: got %0d expected 0", overlap - ov); end
    checks++; if (wr_bad !== wb || hold_bad !== hb) begin failures++; $display("FAIL wr_shape: got wr_bad=%0d hold_bad=%0d expected 0/0", wr_bad - wb, hold_bad - hb); end
    // CHK 37 does not match 01^0A^3D = 36
    t0 = tx_cnt; p0 = cfg_pulses;
    send_frame(8'hA5, 8'h01, 8'h0A, 8'h3D, 8'h37);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'hEE || tx_cnt !== t0 + 1) begin failures++; $display("FAIL tw37_nak: got %h n=%0d expected ee n=1", tx_mem[t0[7:0]], tx_cnt - t0); end
    checks++; if (tuning_word !== 16'h1234 || frame_err_cnt !== 8'd1) begin failures++; $display("FAIL tw37_nochange: got %h err=%0d expected 1234 err=1", tuning_word, frame_err_cnt); end
    checks++; if (cfg_pulses !== p0) begin failures++; $display("FAIL tw37_no_pulse: got %0d expected 0", cfg_pulses - p0); end
    t0 = tx_cnt; p0 = cfg_pulses;
    send_frame(8'hA5, 8'h01, 8'h0A, 8'h3D, 8'h36);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'h5A || tuning_word !== 16'h0A3D) begin failures++; $display("FAIL tw36_ack: got %h tw=%h expected 5a tw=0a3d", tx_mem[t0[7:0]], tuning_word); end
    checks++; if (cfg_pulses - p0 !== 1) begin failures++; $display("FAIL tw36_pulse: got %0d expected 1", cfg_pulses - p0); end
  endtask

  task automatic test_wave_cmd();
    int t0, p0;
    t0 = tx_cnt; p0 = cfg_pulses;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h01, 8'h03);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'h5A || wave_sel !== 3'b010) begin failures++; $display("FAIL wave_tri: got %h wave=%b expected 5a wave=010", tx_mem[t0[7:0]], wave_sel); end
    checks++; if (cfg_pulses - p0 !== 1) begin failures++; $display("FAIL wave_tri_pulse: got %0d expected 1", cfg_pulses - p0); end
    t0 = tx_cnt; p0 = cfg_pulses;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h03, 8'h01);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'hEE || wave_sel !== 3'b010) begin failures++; $display("FAIL wave_sel3_nak: got %h wave=%b expected ee wave=010", tx_mem[t0[7:0]], wave_sel); end
    checks++; if (frame_err_cnt !== 8'd2 || cfg_pulses !== p0) begin failures++; $display("FAIL wave_sel3_err: got err=%0d pulses=%0d expected 2/0", frame_err_cnt, cfg_pulses - p0); end
  endtask

  task automatic test_bad_chk_resync();
    int t0;
    t0 = tx_cnt;
    send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h00);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'hEE || tuning_word !== 16'h0A3D) begin failures++; $display("FAIL badchk: got %h tw=%h expected ee tw=0a3d", tx_mem[t0[7:0]], tuning_word); end
    checks++; if (frame_err_cnt !== 8'd3) begin failures++; $display("FAIL badchk_err: got %0d expected 3", frame_err_cnt); end
    // Junk byte before header, then 0xA5 used as payload
    t0 = tx_cnt;
    push_byte(8'h33);
    send_frame(8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01);
    wait_tx(t0 + 2);
    checks++; if (tx_cnt !== t0 + 1 || tx_mem[t0[7:0]] !== 8'h5A) begin failures++; $display("FAIL resync_ack: got n=%0d byte=%h expected n=1 byte=5a", tx_cnt - t0, tx_mem[t0[7:0]]); end
    checks++; if (tuning_word !== 16'hA5A5) begin failures++; $display("FAIL a5_payload: got %h expected a5a5", tuning_word); end
    t0 = tx_cnt;
    send_frame(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'hEE || frame_err_cnt !== 8'd4) begin failures++; $display("FAIL unknown_cmd: got %h err=%0d expected ee err=4", tx_mem[t0[7:0]], frame_err_cnt); end
  endtask

  task automatic test_enable_key();
    int t0, p0;
    t0 = tx_cnt; p0 = cfg_pulses;
    send_frame(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03);
    wait_tx(t0 + 1);
    checks++; if (da_en !== 1'b0 || tx_mem[t0[7:0]] !== 8'h5A || cfg_pulses - p0 !== 1) begin failures++; $display("FAIL en_off: got da_en=%b resp=%h pulses=%0d expected 0/5a/1", da_en, tx_mem[t0[7:0]], cfg_pulses - p0); end
    p0 = cfg_pulses;
    key_pulse();
    checks++; if (wave_sel !== 3'b010 || cfg_pulses !== p0) begin failures++; $display("FAIL key_disabled: got wave=%b pulses=%0d expected 010/0", wave_sel, cfg_pulses - p0); end
    t0 = tx_cnt;
    send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);
    wait_tx(t0 + 1);
    checks++; if (da_en !== 1'b1) begin failures++; $display("FAIL en_on: got %b expected 1", da_en); end
    p0 = cfg_pulses;
    key_pulse();
    checks++; if (wave_sel !== 3'b100 || cfg_pulses - p0 !== 1) begin failures++; $display("FAIL key_rotate: got wave=%b pulses=%0d expected 100/1", wave_sel, cfg_pulses - p0); end
  endtask

  task automatic test_timeout();
    int t0, w0;
    t0 = tx_cnt; w0 = wr_pulses;
    push_byte(8'hA5); push_byte(8'h03);
    for (int i = 0; i < 200 && rd_ptr != wr_ptr; i++) @(negedge clk);
    wait_cycles(TB_TIMEOUT + 10);
    checks++; if (tx_cnt !== t0 || wr_pulses !== w0) begin failures++; $display("FAIL timeout_silent: got tx=%0d wr=%0d expected 0/0", tx_cnt - t0, wr_pulses - w0); end
    checks++; if (frame_err_cnt !== 8'd5) begin failures++; $display("FAIL timeout_err: got %0d expected 5", frame_err_cnt); end
    t0 = tx_cnt;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h00, 8'h02);
    wait_tx(t0 + 1);
    checks++; if (tx_mem[t0[7:0]] !== 8'h5A || wave_sel !== 3'b001) begin failures++; $display("FAIL after_timeout: got %h wave=%b expected 5a wave=001", tx_mem[t0[7:0]], wave_sel); end
  endtask

  task automatic test_backpressure();
    int t0, s0, s1, w0, wb, hb;
    t0 = tx_cnt; s0 = rd_strobes; w0 = wr_pulses; wb = wr_bad; hb = hold_bad;
    txe_n = 1'b1;
    send_frame(8'hA5, 8'h01, 8'h00, 8'h10, 8'h11);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h01, 8'h03);
    for (int i = 0; i < 500 && (rd_strobes - s0) < 5; i++) @(negedge clk);
    wait_cycles(5);
    s1 = rd_strobes;
    wait_cycles(500);
    checks++; if (rd_strobes !== s1 || rd_strobes - s0 !== 5) begin failures++; $display("FAIL pending_blocks_rd: got strobes=%0d expected 5", rd_strobes - s0); end
    checks++; if (wr_pulses !== w0 || tuning_word !== 16'h0010) begin failures++; $display("FAIL txe_high: got wr=%0d tw=%h expected 0/0010", wr_pulses - w0, tuning_word); end
    txe_n = 1'b0;
    wait_tx(t0 + 2);
    checks++; if (tx_cnt !== t0 + 2 || tx_mem[t0[7:0]] !== 8'h5A) begin failures++; $display("FAIL bp_resume: got n=%0d first=%h expected 2/5a", tx_cnt - t0, tx_mem[t0[7:0]]); end
    checks++; if (wave_sel !== 3'b010 || rd_strobes - s0 !== 10) begin failures++; $display("FAIL bp_second_frame: got wave=%b strobes=%0d expected 010/10", wave_sel, rd_strobes - s0); end
    checks++; if (wr_bad !== wb || hold_bad !== hb) begin failures++; $display("FAIL bp_wr_shape: got wr_bad=%0d hold_bad=%0d expected 0/0", wr_bad - wb, hold_bad - hb); end
  endtask

  task automatic test_key_collision();
    int t0, p0, rises;
    logic prev;
    t0 = tx_cnt; p0 = cfg_pulses; rises = 0; prev = rd_n;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h02, 8'h00);
    for (int i = 0; i < 500 && rises < 5; i++) begin
      @(negedge clk);
      if (!prev && rd_n) rises++;
      prev = rd_n;
    end
    // CHK byte latched at last edge; parser consumes it next edge, execute follows
    @(negedge clk); key_step = 1'b1;
    @(negedge clk); key_step = 1'b0;
    wait_tx(t0 + 1);
    checks++; if (wave_sel !== 3'b100 || tx_mem[t0[7:0]] !== 8'h5A) begin failures++; $display("FAIL collide_wave: got wave=%b resp=%h expected 100/5a", wave_sel, tx_mem[t0[7:0]]); end
    checks++; if (cfg_pulses - p0 !== 1) begin failures++; $display("FAIL collide_pulse: got %0d expected 1", cfg_pulses - p0); end
  endtask

  task automatic test_async_reset();
    int t0, s0;
    t0 = tx_cnt; s0 = rd_strobes;
    txe_n = 1'b1;
    send_frame(8'hA5, 8'h01, 8'h55, 8'hAA, 8'hFE);
    for (int i = 0; i < 500 && (rd_strobes - s0) < 5; i++) @(negedge clk);
    wait_cycles(5);
    checks++; if (tuning_word !== 16'h55AA || frame_err_cnt !== 8'd5) begin failures++; $display("FAIL prereset_state: got tw=%h err=%0d expected 55aa/5", tuning_word, frame_err_cnt); end
    txe_n = 1'b0;
    for (int i = 0; i < 50 && wr !== 1'b1; i++) @(negedge clk);
    checks++; if (wr !== 1'b1 || d_oe !== 1'b1) begin failures++; $display("FAIL tx_strobe_seen: got wr=%b d_oe=%b expected 1/1", wr, d_oe); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr !== 1'b0 || d_oe !== 1'b0 || rd_n !== 1'b1) begin failures++; $display("FAIL async_strobes: got wr=%b d_oe=%b rd_n=%b expected 0/0/1", wr, d_oe, rd_n); end
    checks++; if (tuning_word !== 16'h0A3D || wave_sel !== 3'b001 || da_en !== 1'b1) begin failures++; $display("FAIL async_regs: got tw=%h wave=%b en=%b expected 0a3d/001/1", tuning_word, wave_sel, da_en); end
    checks++; if (frame_err_cnt !== 8'd0 || d_out !== 8'h00 || cfg_update !== 1'b0) begin failures++; $display("FAIL async_misc: got err=%0d d_out=%h cfg=%b expected 0/00/0", frame_err_cnt, d_out, cfg_update); end
    @(negedge clk); rst_n = 1'b1;
    wait_cycles(3);
    t0 = tx_cnt;
    send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);
    wait_tx(t0 + 2);
    checks++; if (tx_cnt !== t0 + 1 || tx_mem[t0[7:0]] !== 8'h5A) begin failures++; $display("FAIL post_reset_frame: got n=%0d resp=%h expected 1/5a", tx_cnt - t0, tx_mem[t0[7:0]]); end
  endtask

  initial begin
    test_reset();
    test_tuning_word();
    test_wave_cmd();
    test_bad_chk_resync();
    test_enable_key();
    test_timeout();
    test_backpressure();
    test_key_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
